// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding, select constants and default widths for the GCD controller
package gcd_pkg;

  localparam int ITER_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_A  = 3'd1,
    S_LD_B  = 3'd2,
    S_CMP   = 3'd3,
    S_SUB_A = 3'd4,
    S_SUB_B = 3'd5,
    S_DONE  = 3'd6
  } gcd_state_e;

  // Subtractor operand selects and bus source selects
  localparam logic SEL_A    = 1'b1;
  localparam logic SEL_B    = 1'b0;
  localparam logic SEL_DATA = 1'b1;
  localparam logic SEL_SUB  = 1'b0;

endpackage

// File: rtl/gcd_ctrl_if.sv
// rtl/gcd_ctrl_if.sv - controller <-> datapath/requester signal bundle; GCD_CTRL_ZERO_CHECK_EN adds zero flags
interface gcd_ctrl_if #(
  parameter int ITER_W = gcd_pkg::ITER_W_DEF
);

  logic              start;
  logic              gt;
  logic              lt;
  logic              eq;
`ifdef GCD_CTRL_ZERO_CHECK_EN
  logic              zero_a;
  logic              zero_b;
`endif
  logic              ldA;
  logic              ldB;
  logic              sel_in;
  logic              sel1;
  logic              sel2;
  logic              req_a;
  logic              req_b;
  logic              busy;
  logic              done;
  logic              err;
  logic [ITER_W-1:0] iter_cnt;

`ifdef GCD_CTRL_ZERO_CHECK_EN
  modport master (
    output start, gt, lt, eq, zero_a, zero_b,
    input  ldA, ldB, sel_in, sel1, sel2, req_a, req_b, busy, done, err, iter_cnt
  );

  modport slave (
    input  start, gt, lt, eq, zero_a, zero_b,
    output ldA, ldB, sel_in, sel1, sel2, req_a, req_b, busy, done, err, iter_cnt
  );
`else
  modport master (
    output start, gt, lt, eq,
    input  ldA, ldB, sel_in, sel1, sel2, req_a, req_b, busy, done, err, iter_cnt
  );

  modport slave (
    input  start, gt, lt, eq,
    output ldA, ldB, sel_in, sel1, sel2, req_a, req_b, busy, done, err, iter_cnt
  );
`endif

endinterface

// File: rtl/gcd_iter_cnt.sv
// rtl/gcd_iter_cnt.sv - saturating subtraction counter with clear, increment and limit-hit flag
module gcd_iter_cnt #(
  parameter int          ITER_W   = 16,
  parameter int unsigned MAX_ITER = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ITER_W-1:0] cnt,
  output logic              limit_hit
);

  localparam logic [ITER_W-1:0] LIMIT   = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] CNT_MAX = '1;
  localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign limit_hit = (cnt >= LIMIT);

endmodule

// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - subtractive GCD controller (Moore FSM); GCD_CTRL_ZERO_CHECK_EN enables zero-operand abort
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int          ITER_W   = ITER_W_DEF,
  parameter int unsigned MAX_ITER = 16'hFFFF
) (
  input  logic     clk,
  input  logic     rst_n,
  gcd_ctrl_if.slave ctl
);

  gcd_state_e        state_q;
  gcd_state_e        state_d;
  logic              err_q;
  logic              set_err;
  logic              run_start;
  logic              cnt_inc;
  logic              limit_hit;
  logic              zero_hit;
  logic [ITER_W-1:0] cnt;

  assign run_start = (state_q == S_IDLE) && ctl.start;
  assign cnt_inc   = (state_q == S_SUB_A) || (state_q == S_SUB_B);

`ifdef GCD_CTRL_ZERO_CHECK_EN
  // Only the compare straight after loading sees the original operands
  logic first_cmp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_cmp_q <= 1'b0;
    end else begin
      first_cmp_q <= (state_q == S_LD_B);
    end
  end

  assign zero_hit = first_cmp_q && (ctl.zero_a ^ ctl.zero_b) && (ctl.gt || ctl.lt);
`else
  assign zero_hit = 1'b0;
`endif

  gcd_iter_cnt #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (run_start),
    .inc       (cnt_inc),
    .cnt       (cnt),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (run_start) begin
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    case (state_q)
      S_IDLE:  if (ctl.start) state_d = S_LD_A;
      S_LD_A:  state_d = S_LD_B;
      S_LD_B:  state_d = S_CMP;
      S_CMP: begin
        // Equality wins even at the iteration limit: that run finished cleanly
        if (ctl.eq) begin
          state_d = S_DONE;
        end else if (zero_hit || limit_hit) begin
          state_d = S_DONE;
          set_err = 1'b1;
        end else if (ctl.gt) begin
          state_d = S_SUB_A;
        end else if (ctl.lt) begin
          state_d = S_SUB_B;
        end
      end
      S_SUB_A: state_d = S_CMP;
      S_SUB_B: state_d = S_CMP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctl.ldA      = 1'b0;
    ctl.ldB      = 1'b0;
    ctl.sel_in   = SEL_SUB;
    ctl.sel1     = SEL_B;
    ctl.sel2     = SEL_B;
    ctl.req_a    = 1'b0;
    ctl.req_b    = 1'b0;
    ctl.busy     = (state_q != S_IDLE);
    ctl.done     = (state_q == S_DONE);
    ctl.err      = err_q;
    ctl.iter_cnt = cnt;
    case (state_q)
      S_LD_A: begin
        ctl.ldA    = 1'b1;
        ctl.sel_in = SEL_DATA;
        ctl.req_a  = 1'b1;
      end
      S_LD_B: begin
        ctl.ldB    = 1'b1;
        ctl.sel_in = SEL_DATA;
        ctl.req_b  = 1'b1;
      end
      S_SUB_A: begin
        ctl.ldA  = 1'b1;
        ctl.sel1 = SEL_A;
        ctl.sel2 = SEL_B;
      end
      S_SUB_B: begin
        ctl.ldB  = 1'b1;
        ctl.sel1 = SEL_B;
        ctl.sel2 = SEL_A;
      end
      default: ;
    endcase
  end

endmodule
